// File: rtl/axi_stream_insert_header_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module   : axi_stream_insert_header_pipe_if
//  Brief    : Bundles the payload, header and output handshakes of the
//             header-insertion pipe. The slave modport is the block side and
//             the master modport is the side that drives it.
//  Revision : 1.0  initial release
// ============================================================================
interface axi_stream_insert_header_pipe_if #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD + 1)
);
    // Payload input
    logic                    valid_in;
    logic                    ready_in;
    logic [DATA_WD-1:0]      data_in;
    logic [DATA_BYTE_WD-1:0] keep_in;
    logic                    last_in;
    // Output stream
    logic                    valid_out;
    logic                    ready_out;
    logic [DATA_WD-1:0]      data_out;
    logic [DATA_BYTE_WD-1:0] keep_out;
    logic                    last_out;
    // Header input
    logic                    valid_insert;
    logic                    ready_insert;
    logic [DATA_WD-1:0]      data_insert;
    logic [DATA_BYTE_WD-1:0] keep_insert;
    logic [BYTE_CNT_WD-1:0]  byte_insert_cnt;
    // Header consistency flag
    logic                    hdr_err;

    modport slave (
        input  valid_in, data_in, keep_in, last_in,
        input  ready_out,
        input  valid_insert, data_insert, keep_insert, byte_insert_cnt,
        output ready_in,
        output valid_out, data_out, keep_out, last_out,
        output ready_insert, hdr_err
    );

    modport master (
        output valid_in, data_in, keep_in, last_in,
        output ready_out,
        output valid_insert, data_insert, keep_insert, byte_insert_cnt,
        input  ready_in,
        input  valid_out, data_out, keep_out, last_out,
        input  ready_insert, hdr_err
    );
endinterface
`default_nettype wire

// File: rtl/axi_stream_insert_header_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : axi_stream_insert_header_pipe
//  Brief    : Prepends a 0..N byte header to an AXI-stream packet. The header
//             bytes sit in a residual register and every payload beat is
//             shifted right by H bytes through one registered output stage.
//             A packet whose tail overflows the last beat gets one FLUSH beat.
//  Revision : 1.0  initial release
// ============================================================================
module axi_stream_insert_header_pipe #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD + 1)
) (
    input  wire logic                         clk,
    input  wire logic                         rst_n,
    axi_stream_insert_header_pipe_if.slave    bus
);

    localparam int N  = DATA_BYTE_WD;
    localparam int SW = $clog2(DATA_WD + 1);
    localparam logic [BYTE_CNT_WD:0]   N_SUM = (BYTE_CNT_WD + 1)'(N);
    localparam logic [BYTE_CNT_WD-1:0] N_CNT = BYTE_CNT_WD'(N);

    typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, FLUSH = 2'd2} state_t;

    // keep vector with the top n lanes (first n bytes) enabled
    function automatic logic [N-1:0] lead_ones(input logic [BYTE_CNT_WD:0] n);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[N-1-i] = (i < int'(n));
        return r;
    endfunction

    // keep vector with the bottom n lanes (right-aligned bytes) enabled
    function automatic logic [N-1:0] low_ones(input logic [BYTE_CNT_WD-1:0] n);
        logic [N-1:0] r;
        for (int i = 0; i < N; i++) r[i] = (i < int'(n));
        return r;
    endfunction

    // expand a per-lane keep into a per-bit data mask
    function automatic logic [DATA_WD-1:0] byte_mask(input logic [N-1:0] k);
        logic [DATA_WD-1:0] m;
        for (int i = 0; i < N; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    // number of contiguous enabled lanes starting at byte 0
    function automatic logic [BYTE_CNT_WD-1:0] count_lead(input logic [N-1:0] k);
        logic                   run;
        logic [BYTE_CNT_WD-1:0] c;
        run = 1'b1;
        c   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            run = run & k[i];
            if (run) c = c + BYTE_CNT_WD'(1);
        end
        return c;
    endfunction

    state_t                  state_q, state_d;
    // header length while streaming; reused as the flush byte count in FLUSH
    logic [BYTE_CNT_WD-1:0]  h_q, h_d;
    // right-aligned carry bytes in STREAM, left-aligned tail bytes in FLUSH
    logic [DATA_WD-1:0]      res_q, res_d;
    logic                    valid_out_q, valid_out_d;
    logic [DATA_WD-1:0]      data_out_q, data_out_d;
    logic [N-1:0]            keep_out_q, keep_out_d;
    logic                    last_out_q, last_out_d;
    logic                    hdr_err_q, hdr_err_d;

    logic                    ld_w;
    logic                    ready_insert_w;
    logic                    clamp_w;
    logic [BYTE_CNT_WD-1:0]  h_clamp_w;
    logic [BYTE_CNT_WD-1:0]  k_w;
    logic [BYTE_CNT_WD:0]    sum_w;
    logic [BYTE_CNT_WD:0]    over_w;
    logic [SW-1:0]           sh_hi_w;
    logic [SW-1:0]           sh_lo_w;
    logic [DATA_WD-1:0]      merged_w;

    // output register may take a new beat when empty or being drained
    assign ld_w           = !valid_out_q || bus.ready_out;
    assign ready_insert_w = (state_q == IDLE) && rst_n;

    assign bus.ready_insert = ready_insert_w;
    assign bus.ready_in     = (state_q == STREAM) && ld_w;
    assign bus.valid_out    = valid_out_q;
    assign bus.data_out     = data_out_q;
    assign bus.keep_out     = keep_out_q;
    assign bus.last_out     = last_out_q;
    assign bus.hdr_err      = hdr_err_q;

    // header length clamp, tail byte count and the shifted merge of carry + payload
    always_comb begin
        clamp_w   = bus.byte_insert_cnt > N_CNT;
        h_clamp_w = clamp_w ? N_CNT : bus.byte_insert_cnt;
        k_w       = count_lead(bus.keep_in);
        sum_w     = {1'b0, h_q} + {1'b0, k_w};
        over_w    = sum_w - N_SUM;
        sh_hi_w   = SW'(8 * (N - int'(h_q)));
        sh_lo_w   = SW'(8 * int'(h_q));
        // a shift by the full width yields zero, covering H=0 and H=N
        merged_w  = (res_q << sh_hi_w) | (bus.data_in >> sh_lo_w);
    end

    // next-state, residual and output-stage update
    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        res_d       = res_q;
        valid_out_d = valid_out_q;
        data_out_d  = data_out_q;
        keep_out_d  = keep_out_q;
        last_out_d  = last_out_q;
        hdr_err_d   = 1'b0;

        if (ld_w) valid_out_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.valid_insert && ready_insert_w) begin
                    h_d       = h_clamp_w;
                    res_d     = bus.data_insert & byte_mask(low_ones(h_clamp_w));
                    hdr_err_d = clamp_w || (bus.keep_insert != low_ones(h_clamp_w));
                    state_d   = STREAM;
                end
            end
            STREAM: begin
                if (bus.valid_in && ld_w) begin
                    valid_out_d = 1'b1;
                    if (!bus.last_in) begin
                        data_out_d = merged_w;
                        keep_out_d = '1;
                        last_out_d = 1'b0;
                        res_d      = bus.data_in & byte_mask(low_ones(h_q));
                    end else if (sum_w <= N_SUM) begin
                        keep_out_d = lead_ones(sum_w);
                        data_out_d = merged_w & byte_mask(lead_ones(sum_w));
                        last_out_d = 1'b1;
                        res_d      = '0;
                        state_d    = IDLE;
                    end else begin
                        data_out_d = merged_w;
                        keep_out_d = '1;
                        last_out_d = 1'b0;
                        res_d      = (bus.data_in << sh_hi_w) & byte_mask(lead_ones(over_w));
                        h_d        = over_w[BYTE_CNT_WD-1:0];
                        state_d    = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (ld_w) begin
                    valid_out_d = 1'b1;
                    data_out_d  = res_q;
                    keep_out_d  = lead_ones({1'b0, h_q});
                    last_out_d  = 1'b1;
                    res_d       = '0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            h_q         <= '0;
            res_q       <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            keep_out_q  <= '0;
            last_out_q  <= 1'b0;
            hdr_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            res_q       <= res_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            keep_out_q  <= keep_out_d;
            last_out_q  <= last_out_d;
            hdr_err_q   <= hdr_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_insert_header_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_stream_insert_header_pipe
//  Brief    : Directed vector bench for the header-insertion pipe (N=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_axi_stream_insert_header_pipe;

    logic clk;
    logic rst_n;

    axi_stream_insert_header_pipe_if #(.DATA_WD(32)) bus ();

    axi_stream_insert_header_pipe #(.DATA_WD(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]       h;
        logic [31:0]      ins;
        logic [3:0]       kins;
        int               nb;
        logic [2:0][31:0] d;
        logic [3:0]       klast;
        int               no;
        logic [3:0][31:0] od;
        logic [3:0][3:0]  ok;
        logic [3:0]       ol;
        int               err;
    } vec_t;

    vec_t vecs [8];
    int   n_vec = 0;
    int   n_err = 0;
    int   err_cnt = 0;
    logic [36:0] q [$];

    // record each output transfer and each hdr_err pulse
    always @(negedge clk) begin
        if (rst_n && bus.valid_out && bus.ready_out)
            q.push_back({bus.data_out, bus.keep_out, bus.last_out});
        if (rst_n && bus.hdr_err) err_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] h, input logic [31:0] ins, input logic [3:0] kins,
                                input int nb, input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [3:0] klast, input int err);
        vec_t v;
        v       = '0;
        v.h     = h;   v.ins = ins;  v.kins = kins; v.nb = nb;
        v.d[0]  = d0;  v.d[1] = d1;  v.d[2] = d2;
        v.klast = klast;
        v.err   = err;
        return v;
    endfunction

    task automatic addo(input int i, input logic [31:0] d, input logic [3:0] k, input logic l);
        vecs[i].od[vecs[i].no] = d;
        vecs[i].ok[vecs[i].no] = k;
        vecs[i].ol[vecs[i].no] = l;
        vecs[i].no++;
    endtask

    task automatic send_hdr(input logic [2:0] c, input logic [31:0] d, input logic [3:0] k);
        logic acc;
        int   n;
        bus.valid_insert = 1'b1; bus.byte_insert_cnt = c; bus.data_insert = d; bus.keep_insert = k;
        acc = 1'b0; n = 0;
        while (!acc && n < 50) begin
            @(negedge clk); acc = bus.ready_insert;
            @(posedge clk); #1; n++;
        end
        bus.valid_insert = 1'b0;
        chk("hdr_accept", {63'd0, acc}, 64'd1);
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        logic acc;
        int   n;
        bus.valid_in = 1'b1; bus.data_in = d; bus.keep_in = k; bus.last_in = l;
        acc = 1'b0; n = 0;
        while (!acc && n < 50) begin
            @(negedge clk); acc = bus.ready_in;
            @(posedge clk); #1; n++;
        end
        bus.valid_in = 1'b0;
        if (!acc) chk("beat_accept", {63'd0, acc}, 64'd1);
    endtask

    task automatic check_out(input string tag, input vec_t v);
        logic [36:0] e;
        for (int c = 0; c < 20 && q.size() < v.no; c++) @(posedge clk);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_count"}, 64'(q.size()), 64'(v.no));
        for (int o = 0; o < v.no; o++) begin
            e = (o < q.size()) ? q[o] : 'x;
            chk($sformatf("%s_data%0d", tag, o), {32'd0, e[36:5]}, {32'd0, v.od[o]});
            chk($sformatf("%s_keep%0d", tag, o), {60'd0, e[4:1]}, {60'd0, v.ok[o]});
            chk($sformatf("%s_last%0d", tag, o), {63'd0, e[0]}, {63'd0, v.ol[o]});
        end
        chk({tag, "_hdr_err"}, 64'(err_cnt), 64'(v.err));
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        q.delete();
        err_cnt = 0;
        send_hdr(v.h, v.ins, v.kins);
        for (int b = 0; b < v.nb; b++)
            send_beat(v.d[b], (b == v.nb - 1) ? v.klast : 4'hF, b == v.nb - 1);
        check_out($sformatf("vec%0d", i), v);
    endtask

    initial begin
        vec_t sv;

        // H=2 spanning two beats with a FLUSH tail
        vecs[0] = mk(3'd2, 32'h0000AABB, 4'b0011, 2, 32'h11223344, 32'h55667788, 0, 4'b1111, 0);
        addo(0, 32'hAABB1122, 4'b1111, 0); addo(0, 32'h33445566, 4'b1111, 0); addo(0, 32'h77880000, 4'b1100, 1);
        // H=0 pass-through
        vecs[1] = mk(3'd0, 32'h0, 4'b0000, 2, 32'h01020304, 32'h05060700, 0, 4'b1110, 0);
        addo(1, 32'h01020304, 4'b1111, 0); addo(1, 32'h05060700, 4'b1110, 1);
        // H=N: header is a standalone first beat
        vecs[2] = mk(3'd4, 32'hAABBCCDD, 4'b1111, 1, 32'h11223344, 0, 0, 4'b1111, 0);
        addo(2, 32'hAABBCCDD, 4'b1111, 0); addo(2, 32'h11223344, 4'b1111, 1);
        // H=3 + K=1 fills exactly one beat, no FLUSH
        vecs[3] = mk(3'd3, 32'h00CCDDEE, 4'b0111, 1, 32'h99000000, 0, 0, 4'b1000, 0);
        addo(3, 32'hCCDDEE99, 4'b1111, 1);
        // keep_insert inconsistent with H=2
        vecs[4] = mk(3'd2, 32'h0000AABB, 4'b0001, 1, 32'h11223344, 0, 0, 4'b1100, 1);
        addo(4, 32'hAABB1122, 4'b1111, 1);
        // count 7 clamps to 4 and flags the header
        vecs[5] = mk(3'd7, 32'hDEADBEEF, 4'b1111, 1, 32'h01020304, 0, 0, 4'b1000, 1);
        addo(5, 32'hDEADBEEF, 4'b1111, 0); addo(5, 32'h01000000, 4'b1000, 1);
        // H=0 with an empty last beat
        vecs[6] = mk(3'd0, 32'h0, 4'b0000, 1, 32'h12345678, 0, 0, 4'b0000, 0);
        addo(6, 32'h00000000, 4'b0000, 1);
        // H=1, last keep has a hole so the byte after it is dropped
        vecs[7] = mk(3'd1, 32'h000000EE, 4'b0001, 2, 32'hAABBCCDD, 32'h11223344, 0, 4'b1101, 0);
        addo(7, 32'hEEAABBCC, 4'b1111, 0); addo(7, 32'hDD112200, 4'b1110, 1);

        rst_n = 1'b0;
        bus.valid_in = 1'b0; bus.data_in = '0; bus.keep_in = '0; bus.last_in = 1'b0;
        bus.ready_out = 1'b1;
        bus.valid_insert = 1'b0; bus.data_insert = '0; bus.keep_insert = '0; bus.byte_insert_cnt = '0;

        // reset state
        #3;
        chk("rst_valid_out", {63'd0, bus.valid_out}, 64'd0);
        chk("rst_ready_in", {63'd0, bus.ready_in}, 64'd0);
        chk("rst_ready_insert", {63'd0, bus.ready_insert}, 64'd0);
        chk("rst_data_keep_last", {27'd0, bus.data_out, bus.keep_out, bus.last_out}, 64'd0);
        chk("rst_hdr_err", {63'd0, bus.hdr_err}, 64'd0);
        #9 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready_insert", {63'd0, bus.ready_insert}, 64'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_vec(i);

        // output stall mid-packet
        sv = mk(3'd2, 32'h0000AABB, 4'b0011, 3, 32'h11223344, 32'h55667788, 32'h99AABBCC, 4'b1111, 0);
        q.delete(); err_cnt = 0;
        fork
            begin
                send_hdr(sv.h, sv.ins, sv.kins);
                send_beat(sv.d[0], 4'hF, 1'b0);
                send_beat(sv.d[1], 4'hF, 1'b0);
                send_beat(sv.d[2], 4'hF, 1'b1);
            end
            begin
                int n;
                n = 0;
                do begin @(negedge clk); n++; end while (!bus.valid_out && n < 50);
                chk("stall_first_valid", {63'd0, bus.valid_out}, 64'd1);
                @(posedge clk); #1;
                bus.ready_out = 1'b0;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    chk("stall_valid", {63'd0, bus.valid_out}, 64'd1);
                    chk("stall_data", {32'd0, bus.data_out}, 64'h33445566);
                    chk("stall_ready_in", {63'd0, bus.ready_in}, 64'd0);
                end
                @(posedge clk); #1;
                bus.ready_out = 1'b1;
            end
        join
        sv.no = 0;
        sv.od[0] = 32'hAABB1122; sv.ok[0] = 4'b1111; sv.ol[0] = 1'b0;
        sv.od[1] = 32'h33445566; sv.ok[1] = 4'b1111; sv.ol[1] = 1'b0;
        sv.od[2] = 32'h778899AA; sv.ok[2] = 4'b1111; sv.ol[2] = 1'b0;
        sv.od[3] = 32'hBBCC0000; sv.ok[3] = 4'b1100; sv.ol[3] = 1'b1;
        sv.no = 4;
        check_out("stall", sv);

        // reset in the middle of a packet
        q.delete(); err_cnt = 0;
        send_hdr(3'd2, 32'h0000AABB, 4'b0011);
        send_beat(32'h11223344, 4'hF, 1'b0);
        bus.ready_out = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid_out", {63'd0, bus.valid_out}, 64'd0);
        chk("mid_rst_data_keep_last", {27'd0, bus.data_out, bus.keep_out, bus.last_out}, 64'd0);
        chk("mid_rst_ready", {62'd0, bus.ready_in, bus.ready_insert}, 64'd0);
        chk("mid_rst_hdr_err", {63'd0, bus.hdr_err}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.ready_out = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_ready_insert", {63'd0, bus.ready_insert}, 64'd1);
        @(posedge clk); #1;
        run_vec(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
